// File: rtl/one_sixteen_demux_pkg.sv
// Shared slot numbering and FSM encodings for the 16:1 select / 1:16 demux pair.
package one_sixteen_demux_pkg;

    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned SEL_W     = 4;

    localparam logic [SEL_W-1:0] FIRST_SLOT = '0;
    localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SEL_W-1:0] slot);
        logic [NUM_SLOTS-1:0] v;
        v = '0;
        v[slot] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/one_sixteen_demux_slot_ctr.sv
// Slot counter for the demux: load-to-1 on sync capture, increment on a valid sample.
module demux_slot_ctr
    import one_sixteen_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);

    logic [SEL_W-1:0] r_sel;

    // Load has priority: a sync sample is always slot 0, so the next slot is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= FIRST_SLOT;
        end else if (i_load) begin
            r_sel <= SEL_W'(1);
        end else if (i_en) begin
            r_sel <= r_sel + 1'b1;
        end
    end

    assign o_sel  = r_sel;
    assign o_last = (r_sel == LAST_SLOT);

endmodule

// File: rtl/one_sixteen_demux.sv
// 1:16 time-division demultiplexer with frame-sync alignment and atomic frame output.
module one_sixteen_demux
    import one_sixteen_demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NUM_SLOTS-1:0] out,
    output logic [SEL_W-1:0]     sel,
    output logic                 locked,
    output logic                 frame_done,
    output logic                 sync_err
);

    state_t               r_state;
    logic [NUM_SLOTS-1:0] r_shadow;
    logic [NUM_SLOTS-1:0] r_out;
    logic                 r_locked;
    logic                 r_done;
    logic                 r_err;

    logic [SEL_W-1:0]     w_sel;
    logic                 w_last;
    logic                 w_run;
    logic                 w_sync_sample;
    logic                 w_accept;
    logic                 w_resync;
    logic                 w_capture;
    logic [SEL_W-1:0]     w_slot;
    logic [NUM_SLOTS-1:0] w_wr_en;

    assign w_run         = (r_state == RUN);
    assign w_sync_sample = din_valid & frame_sync;
    assign w_accept      = din_valid & (w_run | frame_sync);
    assign w_resync      = w_sync_sample & w_run & (w_sel != FIRST_SLOT);
    // A sync at slot 15 is a resync, never a capture.
    assign w_capture     = din_valid & w_run & w_last & ~frame_sync;
    assign w_slot        = frame_sync ? FIRST_SLOT : w_sel;
    assign w_wr_en       = w_accept ? slot_onehot(w_slot) : '0;

    demux_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (din_valid & w_run),
        .i_load (w_sync_sample),
        .o_sel  (w_sel),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HUNT;
            r_shadow <= '0;
            r_out    <= '0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_capture;
            r_err  <= w_resync;

            if (w_sync_sample) begin
                r_state  <= RUN;
                r_locked <= 1'b1;
            end

            // A resync drops the partial frame and restarts it with this sample as slot 0.
            if (w_resync) begin
                r_shadow <= {{(NUM_SLOTS-1){1'b0}}, din};
            end else begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (w_wr_en[i]) begin
                        r_shadow[i] <= din;
                    end
                end
            end

            if (w_capture) begin
                r_out <= {din, r_shadow[NUM_SLOTS-2:0]};
            end
        end
    end

    assign out        = r_out;
    assign sel        = w_sel;
    assign locked     = r_locked;
    assign frame_done = r_done;
    assign sync_err   = r_err;

endmodule
